// File: rtl/datapath_mc_if.sv
// Issue/debug/status bundle between the datapath_mc block and its driver.
interface datapath_mc_if #(
    parameter int WIDTH = 8,
    parameter int AW = 3
);
    logic             start;
    logic [2:0]       op;
    logic [AW-1:0]    ra1;
    logic [AW-1:0]    ra2;
    logic [AW-1:0]    wa3;
    logic             use_imm;
    logic [WIDTH-1:0] imm;
    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output start, op, ra1, ra2, wa3, use_imm, imm, dbg_addr,
        input  dbg_data, busy, done, result, zero
    );

    modport slave (
        input  start, op, ra1, ra2, wa3, use_imm, imm, dbg_addr,
        output dbg_data, busy, done, result, zero
    );
endinterface

// File: rtl/datapath_mc.sv
// Multi-cycle datapath: register file, single-cycle ALU ops, iterative
// shifter and shift-add multiplier sequenced by an IDLE/EXEC FSM.
module datapath_mc #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input logic          iCLK,
    input logic          iRST_N,
    datapath_mc_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_SLT, OP_SLL, OP_SRL, OP_MUL
    } op_e;

    typedef enum logic {IDLE, EXEC} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rf [NREGS];
    logic [WIDTH-1:0] a_q, b_q, acc_q, res_q;
    op_e              op_q;
    logic [AW-1:0]    wa_q;
    logic [CW-1:0]    cnt_q;
    logic             done_q, zero_q;

    logic             issue, fin;
    logic             is_alu, is_sh, is_mul;
    logic [WIDTH-1:0] src_a, src_b, alu, res_d, step;
    op_e              op_in;

    assign op_in = op_e'(bus.op);
    assign src_a = (bus.ra1 == '0) ? '0 : rf[bus.ra1];
    assign src_b = bus.use_imm ? bus.imm :
                   (bus.ra2 == '0) ? '0 : rf[bus.ra2];
    assign issue = (state_q == IDLE) && bus.start;

    assign is_mul = (op_q == OP_MUL);
    assign is_sh  = (op_q == OP_SLL) || (op_q == OP_SRL);
    assign is_alu = !is_mul && !is_sh;
    // a_q doubles as shift register and shifted multiplicand
    assign step   = (op_q == OP_SRL) ? a_q >> 1 : a_q << 1;

    always_comb begin
        alu = '0;
        unique case (op_q)
            OP_ADD:  alu = a_q + b_q;
            OP_SUB:  alu = a_q - b_q;
            OP_AND:  alu = a_q & b_q;
            OP_OR:   alu = a_q | b_q;
            OP_SLT:  alu = WIDTH'($signed(a_q) < $signed(b_q));
            default: alu = '0;
        endcase
    end

    always_comb begin
        fin   = 1'b0;
        res_d = alu;
        unique case (1'b1)
            is_alu: fin = 1'b1;
            is_sh: begin
                fin   = (cnt_q <= CW'(1));
                res_d = (cnt_q == '0) ? a_q : step;
            end
            is_mul: begin
                fin   = (cnt_q == CW'(1));
                res_d = acc_q + (b_q[0] ? a_q : '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = EXEC;
            EXEC:    if (fin) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            res_q  <= '0;
            op_q   <= OP_ADD;
            wa_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (issue) begin
                a_q   <= src_a;
                b_q   <= src_b;
                op_q  <= op_in;
                wa_q  <= bus.wa3;
                acc_q <= '0;
                cnt_q <= (op_in == OP_MUL) ? CW'(WIDTH)
                                           : CW'(src_b[SW-1:0]);
            end else if (state_q == EXEC) begin
                a_q   <= step;
                b_q   <= b_q >> 1;
                acc_q <= res_d;
                if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                if (fin) begin
                    res_q  <= res_d;
                    zero_q <= (res_d == '0);
                    done_q <= 1'b1;
                    if (wa_q != '0) rf[wa_q] <= res_d;
                end
            end
        end
    end

    assign bus.busy     = (state_q == EXEC);
    assign bus.done     = done_q;
    assign bus.result   = res_q;
    assign bus.zero     = zero_q;
    assign bus.dbg_data = (bus.dbg_addr == '0) ? '0 : rf[bus.dbg_addr];
endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc: scoreboard of expected completions
// checked against result/zero/done timing and debug register reads.
module tb_datapath_mc;
    localparam int WIDTH = 8;
    localparam int NREGS = 8;
    localparam int AW    = 3;

    localparam logic [2:0] ADD = 3'd0;
    localparam logic [2:0] SUB = 3'd1;
    localparam logic [2:0] AND = 3'd2;
    localparam logic [2:0] OR  = 3'd3;
    localparam logic [2:0] SLT = 3'd4;
    localparam logic [2:0] SLL = 3'd5;
    localparam logic [2:0] SRL = 3'd6;
    localparam logic [2:0] MUL = 3'd7;

    typedef struct {
        logic [7:0] res;
        logic       zero;
        int         cyc;
    } exp_t;

    logic iCLK = 1'b0;
    logic iRST_N = 1'b0;
    always #5 iCLK = ~iCLK;

    datapath_mc_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    datapath_mc #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .iCLK  (iCLK),
        .iRST_N(iRST_N),
        .bus   (bus)
    );

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] mreg [NREGS];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         n_done = 0;
    int         cyc = 0;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge iCLK) begin
        if (bus.done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("spurious_done", {31'd0, bus.done}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("result", {24'd0, bus.result}, {24'd0, mon_e.res});
                chk("zero", {31'd0, bus.zero}, {31'd0, mon_e.zero});
                chk("latency", cyc, mon_e.cyc);
            end
        end
    end

    function automatic logic [7:0] model(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            AND:     return a & b;
            OR:      return a | b;
            SLT:     return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            SLL:     return a << b[2:0];
            SRL:     return a >> b[2:0];
            default: return p[7:0];
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input int r1, input int r2,
                         input int w, input logic ui, input logic [7:0] im,
                         input bit keep = 0, input bit push = 1);
        logic [7:0] a, b, r;
        int ex;
        exp_t e;
        @(negedge iCLK);
        bus.op = op;
        bus.ra1 = 3'(r1);
        bus.ra2 = 3'(r2);
        bus.wa3 = 3'(w);
        bus.use_imm = ui;
        bus.imm = im;
        bus.start = 1'b1;
        a = mreg[r1];
        b = ui ? im : mreg[r2];
        r = model(op, a, b);
        if (op == MUL) ex = 8;
        else if (op == SLL || op == SRL) ex = (b[2:0] == 0) ? 1 : int'(b[2:0]);
        else ex = 1;
        if (push) begin
            e.res = r;
            e.zero = (r == 8'd0);
            e.cyc = cyc + 1 + ex;
            sb.push_back(e);
            if (w != 0) mreg[w] = r;
        end
        @(posedge iCLK);
        #1;
        if (!keep) bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge iCLK);
            #1;
            n++;
        end
        chk({tag, "_timeout"}, sb.size(), 0);
    endtask

    task automatic dbg_chk(input string tag, input int addr);
        bus.dbg_addr = 3'(addr);
        #1;
        chk(tag, {24'd0, bus.dbg_data}, {24'd0, mreg[addr]});
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 0);
        chk({tag, "_done"}, {31'd0, bus.done}, 0);
        chk({tag, "_result"}, {24'd0, bus.result}, 0);
        chk({tag, "_zero"}, {31'd0, bus.zero}, 0);
        for (int i = 0; i < NREGS; i++) begin
            bus.dbg_addr = 3'(i);
            #1;
            chk({tag, "_reg"}, {24'd0, bus.dbg_data}, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nd;
        bus.start = 1'b0;
        bus.op = ADD;
        bus.ra1 = '0;
        bus.ra2 = '0;
        bus.wa3 = '0;
        bus.use_imm = 1'b0;
        bus.imm = '0;
        bus.dbg_addr = '0;
        for (int i = 0; i < NREGS; i++) mreg[i] = 8'd0;
        #2;
        reset_chk("por");
        @(posedge iCLK);
        #1 iRST_N = 1'b1;

        issue(ADD, 0, 0, 1, 1'b1, 8'h05);
        wait_done("add_imm");
        dbg_chk("dbg_r1", 1);

        issue(SLL, 1, 0, 2, 1'b1, 8'h03);
        wait_done("sll3");
        issue(SRL, 2, 0, 3, 1'b1, 8'h08);
        wait_done("srl_k0");

        issue(ADD, 0, 0, 3, 1'b1, 8'h0D);
        wait_done("ld_r3");
        issue(ADD, 0, 0, 4, 1'b1, 8'h0B);
        wait_done("ld_r4");
        issue(MUL, 3, 4, 5, 1'b0, 8'h00);
        wait_done("mul_rr");
        dbg_chk("dbg_r5", 5);

        issue(ADD, 0, 0, 3, 1'b1, 8'h20);
        wait_done("ld_r3b");
        issue(MUL, 3, 0, 6, 1'b1, 8'h10);
        wait_done("mul_zero");

        issue(SUB, 0, 0, 6, 1'b1, 8'h02);
        wait_done("sub_neg");
        issue(SLT, 6, 0, 7, 1'b1, 8'h01);
        wait_done("slt_signed");
        issue(ADD, 6, 0, 0, 1'b1, 8'h01);
        wait_done("add_r0");
        dbg_chk("dbg_r0", 0);
        dbg_chk("dbg_r7", 7);

        issue(AND, 6, 0, 1, 1'b1, 8'h3C);
        wait_done("and_imm");
        issue(OR, 1, 5, 2, 1'b0, 8'h00);
        wait_done("or_rr");
        issue(SRL, 6, 0, 4, 1'b1, 8'h03);
        wait_done("srl3");
        dbg_chk("dbg_r4", 4);

        issue(ADD, 0, 0, 1, 1'b1, 8'h07, 1'b1);
        @(negedge iCLK);
        @(posedge iCLK);
        #1;
        chk("b2b_done_cycle", {31'd0, bus.done}, 1);
        issue(ADD, 1, 0, 2, 1'b1, 8'h01);
        wait_done("b2b");
        dbg_chk("dbg_b2b_r2", 2);

        issue(MUL, 6, 0, 5, 1'b1, 8'h03, 1'b0, 1'b0);
        @(negedge iCLK);
        bus.op = ADD;
        bus.start = 1'b1;
        @(posedge iCLK);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        chk("abort_busy_pre", {31'd0, bus.busy}, 1);
        nd = n_done;
        iRST_N = 1'b0;
        #1;
        for (int i = 0; i < NREGS; i++) mreg[i] = 8'd0;
        reset_chk("abort");
        repeat (3) @(negedge iCLK);
        chk("abort_no_done", n_done, nd);
        @(posedge iCLK);
        #1 iRST_N = 1'b1;
        issue(ADD, 0, 0, 1, 1'b1, 8'h09);
        wait_done("post_rst");
        dbg_chk("dbg_post_r1", 1);
        dbg_chk("dbg_post_r5", 5);

        repeat (2) @(negedge iCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/datapath_mc.md
DATAPATH_MC -- requirements
Module: datapath_mc

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 8, data width in bits (>=4).
- NREGS, default 8, register count (power of 2, >=2).
- AW = log2(NREGS), derived address width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- iCLK  in  1  single clock; all state changes on its rising edge.
- iRST_N  in  1  reset, asynchronous, active-low.
- start  in  1  request to issue one instruction.
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed), 101 SLL, 110 SRL, 111 MUL.
- ra1, ra2, wa3  in  AW  source A, source B and destination register addresses.
- use_imm  in  1  1 = operand B is imm; 0 = operand B is reg[ra2].
- imm  in  WIDTH  immediate operand.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  WIDTH  reg[dbg_addr], combinational.
- busy  out  1  high while an instruction is in flight.
- done  out  1  one-cycle pulse on completion.
- result  out  WIDTH  last completed result; held between instructions.
- zero  out  1  (result == 0) of last completed instruction; held.

Function
REQ-003 The register file SHALL hold NREGS x WIDTH registers, with reg[0] reading 0 and writes to it discarded.

REQ-004 The FSM SHALL have two states, IDLE and EXEC, with busy = (state == EXEC).

REQ-005 In IDLE, start=1 at an edge SHALL:
- latch A = reg[ra1];
- latch B = use_imm ? imm : reg[ra2];
- latch op and wa3;
- load the iteration counter;
- move the FSM to EXEC.

REQ-006 start SHALL be ignored while busy=1, with no queuing.

REQ-007 Operands SHALL be read at the issue edge, so a write made at the previous edge is visible (no hazard).

REQ-008 Ops 000-100 SHALL complete at the first EXEC edge, with all arithmetic modulo 2^WIDTH:
- ADD: A+B.
- SUB: A-B.
- AND, OR: bitwise.
- SLT: 1 if signed A < signed B, else 0, zero-extended.

REQ-009 SLL and SRL SHALL be iterative:
- k = B[log2(WIDTH)-1:0], the upper bits of B ignored.
- One bit is shifted per EXEC edge, with zero fill.
- The op completes at EXEC edge k, or at EXEC edge 1 when k=0.

REQ-010 MUL SHALL be shift-add over exactly WIDTH EXEC edges, and its result SHALL be the low WIDTH bits of the product.

REQ-011 At the completing edge the block SHALL, in one edge:
- write reg[wa3] = result (skipped if wa3=0);
- update result and zero;
- set done=1 for exactly the following cycle;
- return the FSM to IDLE.

REQ-012 Total latency from the issue edge to the done cycle SHALL be:
- 1 + 1 edges for ops 000-100;
- 1 + max(k,1) edges for SLL/SRL;
- 1 + WIDTH edges for MUL.

REQ-013 start=1 during the done cycle SHALL be accepted, so back-to-back issue needs no idle gap.

REQ-014 A write to reg[0] SHALL still update result, zero and done.

REQ-015 dbg_data SHALL reflect a write from the edge after that write.

Reset
REQ-016 When iRST_N=0 the block SHALL immediately, without waiting for an edge:
- clear all registers to 0;
- set state to IDLE;
- drive busy=0, done=0, result=0, zero=0;
- clear the internal operand, counter and op registers.

REQ-017 Reset asserted during EXEC SHALL abort the instruction with no writeback and no done pulse.

REQ-018 The first start after iRST_N rises SHALL be accepted at the first edge.

Verification (WIDTH=8, NREGS=8)
REQ-019 ADD r1 = r0 + imm 0x05 (use_imm=1) -> done 2 edges after issue; result=0x05; zero=0; dbg_addr=1 reads 0x05.

REQ-020 SLL r2 = r1, imm 0x03 -> busy for 3 EXEC edges; result=0x28. Then SRL with imm 0x08 -> k=0, completes in 1 EXEC edge; result=0x28.

REQ-021 Load r3=0x0D and r4=0x0B, then MUL r5 = r3*r4 (use_imm=0) -> done 9 edges after issue; result=0x8F. MUL 0x20*0x10 -> result=0x00, zero=1.

REQ-022 SUB r6 = r0 - imm 0x02 -> 0xFE. Then SLT r7 = r6, imm 0x01 -> 0x01. Then ADD r0 = r6 + imm 0x01 -> result=0xFF with done, and reg[0] still reads 0.

REQ-023 Issue MUL, pulse start with op=ADD mid-flight, then assert iRST_N=0 at EXEC edge 4 -> the ADD is ignored; busy=0 and all registers read 0 immediately; no done pulse.

REQ-024 Back-to-back: ADD r1 = r0 + imm 0x07, with start held so the next ADD r2 = r1 + imm 0x01 issues in the done cycle -> r2=0x08; done pulses on 2 consecutive-issue boundaries.
